mf_serial_driver: RTL and testbench

Bit-serial operand sequencer that sits directly upstream of the multifunction gate cell (mfGate) and drives it.
- Accepts a WIDTH-bit operand pair plus a 2-bit function select over a valid/ready handshake.
- Presents one bit pair per clock to the gate and collects the gate's f output into a result word.
- Returns the result word over a second valid/ready handshake.

---
 rtl/mf_pkg.sv | 32 +++
 rtl/mf_drv_shifter.sv | 69 ++++++
 rtl/mf_serial_driver.sv | 128 ++++++++++++
 tb/tb_mf_serial_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mf_pkg.sv
// Shared types, op encodings and gate function for mf_serial_driver.
// Checker enabled by defining MF_DRIVER_CHECK_EN.
package mf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mf_drv_state_t;

  localparam logic [1:0] OP_PASS_X  = 2'b00;
  localparam logic [1:0] OP_PASS_Y0 = 2'b01;
  localparam logic [1:0] OP_PASS_Y1 = 2'b10;
  localparam logic [1:0] OP_INV_X   = 2'b11;

  function automatic logic mf_eval(
    input logic       x,
    input logic       y,
    input logic [1:0] op
  );
    logic f;
    case (op)
      OP_PASS_X:  f = x;
      OP_INV_X:   f = ~x;
      OP_PASS_Y0,
      OP_PASS_Y1: f = y;
      default:    f = y;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mf_drv_shifter.sv
// Operand/result shift registers and bit counter for mf_serial_driver.
// Sequencing lives in the top; this block only loads and shifts.
module mf_drv_shifter
  import mf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] x_word,
  input  logic [WIDTH-1:0] y_word,
  input  logic             f_in,
  output logic             xs_lsb,
  output logic             ys_lsb,
  output logic [WIDTH-1:0] res,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign last = (cnt_q == CNT_LAST);

  always_comb begin
    xs_d  = xs_q;
    ys_d  = ys_q;
    res_d = res_q;
    cnt_d = cnt_q;
    if (load) begin
      xs_d  = x_word;
      ys_d  = y_word;
      cnt_d = '0;
    end else if (shift) begin
      xs_d  = xs_q >> 1;
      ys_d  = ys_q >> 1;
      res_d = {f_in, res_q[WIDTH-1:1]};
      // Saturate on the last bit so the counter never wraps.
      if (!last) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q  <= '0;
      ys_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign xs_lsb = xs_q[0];
  assign ys_lsb = ys_q[0];
  assign res    = res_q;

endmodule

// File: rtl/mf_serial_driver.sv
// Bit-serial sequencer feeding the mfGate cell over valid/ready.
// Define MF_DRIVER_CHECK_EN to enable the gate output checker.
module mf_serial_driver
  import mf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_word,
  input  logic [WIDTH-1:0] y_word,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             gate_x,
  output logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_f,
  output logic             err_sticky
);

  mf_drv_state_t state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          load;
  logic          shift;
  logic          xs_lsb;
  logic          ys_lsb;
  logic          last;

  mf_drv_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .x_word (x_word),
    .y_word (y_word),
    .f_in   (gate_f),
    .xs_lsb (xs_lsb),
    .ys_lsb (ys_lsb),
    .res    (result),
    .last   (last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    gate_x    = 1'b0;
    gate_y    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          op_d    = op;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        shift  = 1'b1;
        gate_x = xs_lsb;
        gate_y = ys_lsb;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Function select is held between requests, not only while shifting.
  assign gate_a = op_q[1];
  assign gate_b = op_q[0];

`ifdef MF_DRIVER_CHECK_EN
  logic err_q, err_d;
  logic exp_f;

  always_comb begin
    exp_f = mf_eval(xs_lsb, ys_lsb, op_q);
    err_d = err_q | (shift & (gate_f != exp_f));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mf_serial_driver.sv
// Randomized + directed bench for mf_serial_driver with a word-level model.
// Gate cell behaviour is modelled inline; force_zero pins gate_f low.
module tb_mf_serial_driver;
  import mf_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x_word = '0;
  logic [W-1:0] y_word = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;
  logic         gate_x, gate_y, gate_a, gate_b;
  logic         gate_f;
  logic         err_sticky;
  logic         force_zero = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Gate cell: a==b selects x (inverted when a=1), a!=b selects y.
  assign gate_f = force_zero ? 1'b0 :
                  ((gate_a == gate_b) ? (gate_x ^ gate_a) : gate_y);

  mf_serial_driver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_word     (x_word),
    .y_word     (y_word),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy),
    .gate_x     (gate_x),
    .gate_y     (gate_y),
    .gate_a     (gate_a),
    .gate_b     (gate_b),
    .gate_f     (gate_f),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Word-level model: phase 0 idle, 1..W serial bit k-1, W+1 result ready.
  int           m_ph = 0;
  logic [W-1:0] m_x = '0, m_y = '0, m_true = '0, m_res = '0;
  logic [1:0]   m_op = 2'b00;
  logic         m_err = 1'b0;
  logic         m_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph  = 0;
      m_op  = 2'b00;
      m_err = 1'b0;
    end else if (m_ph == 0) begin
      if (in_valid) begin
        m_x    = x_word;
        m_y    = y_word;
        m_op   = op;
        m_true = (op == 2'b00) ? x_word :
                 (op == 2'b11) ? ~x_word : y_word;
        m_res  = force_zero ? '0 : m_true;
        m_ph   = 1;
      end
    end else if (m_ph <= W) begin
`ifdef MF_DRIVER_CHECK_EN
      if (force_zero && m_true[m_ph-1]) m_err = 1'b1;
`endif
      m_ph = m_ph + 1;
    end else if (out_ready) begin
      m_ph = 0;
    end
  end

  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("in_ready", in_ready, m_ph == 0);
      chk("out_valid", out_valid, m_ph == W + 1);
      chk("busy", busy, m_ph != 0);
      chk("gate_ab", {gate_a, gate_b}, m_op);
      chk("gate_x", gate_x,
          (m_ph >= 1 && m_ph <= W) ? m_x[m_ph-1] : 1'b0);
      chk("gate_y", gate_y,
          (m_ph >= 1 && m_ph <= W) ? m_y[m_ph-1] : 1'b0);
      chk("err_sticky", err_sticky, m_err);
      if (m_ph == W + 1) chk("result", result, m_res);
    end
  end

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [1:0] o, input int hold, input bit pulse,
                     input bit lit_en, input logic [W-1:0] lit);
    int n;
    logic [W-1:0] held;
    @(negedge clk);
    in_valid = 1'b1;
    x_word = x;
    y_word = y;
    op = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_word = W'($urandom);
    y_word = W'($urandom);
    op = 2'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (pulse) begin
        in_valid = (n == 3);
        x_word = ~x;
        op = ~o;
      end
    end while (!out_valid && n < 40);
    in_valid = 1'b0;
    chk("latency", n, W);
    if (lit_en) chk("lit_result", result, lit);
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse;
      @(posedge clk);
      #1;
      chk("bp_stable", result, held);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_idle", in_ready, 1'b1);
    chk("post_ovalid", out_valid, 1'b0);
  endtask

  initial begin
    #23;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_gates", {gate_x, gate_y, gate_a, gate_b}, 4'b0000);
    chk("rst_err", err_sticky, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_on = 1'b1;

    run(8'hA5, 8'h3C, 2'b00, 0, 1'b0, 1'b1, 8'hA5);
    run(8'hA5, 8'h3C, 2'b11, 0, 1'b0, 1'b1, 8'h5A);
    run(8'hA5, 8'h3C, 2'b01, 0, 1'b0, 1'b1, 8'h3C);
    run(8'hA5, 8'h3C, 2'b10, 0, 1'b0, 1'b1, 8'h3C);
    run(8'h96, 8'h11, 2'b00, 5, 1'b0, 1'b1, 8'h96);
    run(8'hFF, 8'h00, 2'b11, 0, 1'b0, 1'b1, 8'h00);
    run(8'hC3, 8'h5A, 2'b10, 3, 1'b1, 1'b1, 8'h5A);

    // Reset mid-operation.
    @(negedge clk);
    in_valid = 1'b1;
    x_word = 8'hF0;
    y_word = 8'hAA;
    op = 2'b11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_gates", {gate_x, gate_y, gate_a, gate_b}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    run(8'h0F, 8'h77, 2'b00, 0, 1'b0, 1'b1, 8'h0F);

    // Gate output pinned low: checker flags it only when compiled in.
    force_zero = 1'b1;
    run(8'h01, 8'h00, 2'b00, 2, 1'b0, 1'b1, 8'h00);
    force_zero = 1'b0;
    run(8'h5C, 8'h00, 2'b00, 0, 1'b0, 1'b1, 8'h5C);
`ifdef MF_DRIVER_CHECK_EN
    chk("err_held", err_sticky, 1'b1);
`else
    chk("err_tied", err_sticky, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_cleared", err_sticky, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] rx, ry;
      logic [1:0]   ro;
      rx = W'($urandom);
      ry = W'($urandom);
      ro = 2'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run(rx, ry, ro, $urandom_range(0, 4), 1'($urandom), 1'b0, '0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
